// File: rtl/svc_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// svc_rst_seq_pkg
// Shared definitions for the reset sequencer:
//   - FSM state encodings (plain localparams plus a matching enum type)
//   - default parameter values and the counter widths derived from them
//   - cnt_w(): width helper for counters that count 0..n-1
//   - reset_count saturation limit
// -----------------------------------------------------------------------------
package svc_rst_seq_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_HOLD      = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
   localparam logic [1:0] ST_RELEASE   = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   typedef enum logic [1:0] {
      HOLD      = ST_HOLD,
      WAIT_LOCK = ST_WAIT_LOCK,
      RELEASE   = ST_RELEASE,
      RUN       = ST_RUN
   } state_e;

   // Width of a counter that must reach the value n-1 (never narrower than 1)
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Default configuration
   localparam int DEF_NUM_STAGES   = 3;
   localparam int DEF_HOLD_CYCLES  = 16;
   localparam int DEF_STAGE_GAP    = 4;
   localparam int DEF_LOCK_TIMEOUT = 1024;
   localparam int DEF_WDT_CYCLES   = 65536;

   // Counter widths for the default configuration
   localparam int HOLD_CNT_W = $clog2(DEF_HOLD_CYCLES);
   localparam int GAP_CNT_W  = $clog2(DEF_STAGE_GAP);
   localparam int TO_CNT_W   = $clog2(DEF_LOCK_TIMEOUT);
   localparam int WDT_CNT_W  = $clog2(DEF_WDT_CYCLES);

   // reset_count saturates here and never wraps
   localparam int RESET_COUNT_MAX = 255;
   localparam int RESET_COUNT_W   = 8;

endpackage

// File: rtl/svc_sat_counter.sv
// -----------------------------------------------------------------------------
// svc_sat_counter
// Generic up-counter with synchronous clear and enable that stops at MAX.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (count -> 0)
//   i_clr    synchronous clear (count -> 0), dominates i_en
//   i_en     count enable; ignored once the count equals MAX
//   o_count  current count
// -----------------------------------------------------------------------------
module svc_sat_counter #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != MAX_V)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/svc_rst_seq.sv
// -----------------------------------------------------------------------------
// svc_rst_seq
// Reset sequencer: holds all domain resets, waits for clock lock, then
// releases stage_rst[0..NUM_STAGES-1] in ascending order STAGE_GAP cycles
// apart and raises ready. Lock loss or a software request in RELEASE/RUN
// reasserts every stage on the next edge and restarts from HOLD.
//
// Optional feature (macro SVC_RST_SEQ_WDT_EN): a RUN-state watchdog that
// restarts the sequence after WDT_CYCLES cycles without a wdt_kick.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high raw reset
//   locked       clock source stable
//   sw_rst_req   single-cycle software reset request
//   wdt_kick     watchdog kick (SVC_RST_SEQ_WDT_EN only)
//   wdt_fired    sticky watchdog-fired flag (SVC_RST_SEQ_WDT_EN only)
//   stage_rst    per-domain resets, active-high, bit 0 released first
//   ready        all stages released and sequencer in RUN
//   lock_fail    sticky lock-timeout flag, cleared only by rst
//   reset_count  saturating count of sw/watchdog-triggered resets
// -----------------------------------------------------------------------------
module svc_rst_seq
   import svc_rst_seq_pkg::*;
#(
   parameter int NUM_STAGES   = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP    = DEF_STAGE_GAP,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int WDT_CYCLES   = DEF_WDT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  locked,
   input  logic                  sw_rst_req,
`ifdef SVC_RST_SEQ_WDT_EN
   input  logic                  wdt_kick,
   output logic                  wdt_fired,
`endif
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  ready,
   output logic                  lock_fail,
   output logic [7:0]            reset_count
);

   localparam int HOLD_W = cnt_w(HOLD_CYCLES);
   localparam int GAP_W  = cnt_w(STAGE_GAP);
   localparam int TO_W   = cnt_w(LOCK_TIMEOUT);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [NUM_STAGES-1:0] r_stage_rst;
   logic [NUM_STAGES-1:0] w_stage_nxt;
   logic                  r_ready;
   logic                  r_lock_fail;

   logic [HOLD_W-1:0]     w_hold_cnt;
   logic [GAP_W-1:0]      w_gap_cnt;
   logic [TO_W-1:0]       w_to_cnt;
   logic [7:0]            w_rc_cnt;

   logic                  w_hold_done;
   logic                  w_gap_done;
   logic                  w_timeout;
   logic                  w_abort;
   logic                  w_all_rel;
   logic                  w_wdt_fire;
   logic                  w_rc_inc;

   // ---------------------------------------------------------------------
   // Event decode
   // ---------------------------------------------------------------------
   // A software request in HOLD restarts the count, so it also blocks the
   // HOLD -> WAIT_LOCK exit in the same cycle.
   assign w_hold_done = (r_state == ST_HOLD) && (w_hold_cnt == HOLD_LAST) && !sw_rst_req;
   assign w_gap_done  = (r_state == ST_RELEASE) && (w_gap_cnt == GAP_LAST);
   assign w_timeout   = (r_state == ST_WAIT_LOCK) && !locked && (w_to_cnt == TO_LAST);
   assign w_abort     = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) &&
                        (!locked || sw_rst_req);
   assign w_all_rel   = (r_stage_rst == '0);
   assign w_rc_inc    = sw_rst_req || w_wdt_fire;

   // ---------------------------------------------------------------------
   // Next state and next stage vector
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_HOLD: begin
            if (w_hold_done) w_next_state = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (w_timeout || sw_rst_req) w_next_state = ST_HOLD;
            else if (locked)             w_next_state = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (w_abort)        w_next_state = ST_HOLD;
            else if (w_all_rel) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (w_abort || w_wdt_fire) w_next_state = ST_HOLD;
         end
         default: w_next_state = ST_HOLD;
      endcase
   end

   // Releases only ever shift a zero in from bit 0, so stages can only
   // release in ascending order; any return to HOLD reasserts all of them.
   always_comb begin
      w_stage_nxt = r_stage_rst;
      if (w_next_state == ST_HOLD) begin
         w_stage_nxt = '1;
      end else if ((r_state == ST_WAIT_LOCK) && (w_next_state == ST_RELEASE)) begin
         w_stage_nxt = r_stage_rst << 1;
      end else if ((r_state == ST_RELEASE) && (w_next_state == ST_RELEASE) && w_gap_done) begin
         w_stage_nxt = r_stage_rst << 1;
      end else if (w_next_state == ST_RUN) begin
         w_stage_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_HOLD;
         r_stage_rst <= '1;
         r_ready     <= 1'b0;
         r_lock_fail <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_stage_rst <= w_stage_nxt;
         r_ready     <= (w_next_state == ST_RUN);
         r_lock_fail <= r_lock_fail || w_timeout;
      end
   end

   // ---------------------------------------------------------------------
   // Counters. Each one is held at zero outside its own state so that
   // every entry into that state starts counting from zero.
   // ---------------------------------------------------------------------
   svc_sat_counter #(.WIDTH(HOLD_W), .MAX(HOLD_CYCLES - 1)) u_hold_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   ((r_state != ST_HOLD) || sw_rst_req || w_hold_done),
      .i_en    (r_state == ST_HOLD),
      .o_count (w_hold_cnt)
   );

   svc_sat_counter #(.WIDTH(GAP_W), .MAX(STAGE_GAP - 1)) u_gap_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   ((r_state != ST_RELEASE) || w_gap_done),
      .i_en    (r_state == ST_RELEASE),
      .o_count (w_gap_cnt)
   );

   // Counts consecutive unlocked cycles; any locked cycle restarts it.
   svc_sat_counter #(.WIDTH(TO_W), .MAX(LOCK_TIMEOUT - 1)) u_to_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   ((r_state != ST_WAIT_LOCK) || locked || w_timeout),
      .i_en    ((r_state == ST_WAIT_LOCK) && !locked),
      .o_count (w_to_cnt)
   );

   svc_sat_counter #(.WIDTH(8), .MAX(RESET_COUNT_MAX)) u_rc_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (1'b0),
      .i_en    (w_rc_inc),
      .o_count (w_rc_cnt)
   );

`ifdef SVC_RST_SEQ_WDT_EN
   localparam int WDT_W = cnt_w(WDT_CYCLES);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] w_wdt_cnt;
   logic             r_wdt_fired;

   // Lowest priority restart source: lock loss and sw requests win.
   assign w_wdt_fire = (r_state == ST_RUN) && (w_wdt_cnt == WDT_LAST) &&
                       !wdt_kick && locked && !sw_rst_req;

   svc_sat_counter #(.WIDTH(WDT_W), .MAX(WDT_CYCLES - 1)) u_wdt_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   ((r_state != ST_RUN) || wdt_kick || w_wdt_fire),
      .i_en    (r_state == ST_RUN),
      .o_count (w_wdt_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) r_wdt_fired <= 1'b0;
      else     r_wdt_fired <= r_wdt_fired || w_wdt_fire;
   end

   assign wdt_fired = r_wdt_fired;
`else
   assign w_wdt_fire = 1'b0;
`endif

   assign stage_rst   = r_stage_rst;
   assign ready       = r_ready;
   assign lock_fail   = r_lock_fail;
   assign reset_count = w_rc_cnt;

endmodule

// File: tb/tb_svc_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_svc_rst_seq
// Self-checking bench for svc_rst_seq with default parameters (watchdog
// period overridden to 64 for the optional SVC_RST_SEQ_WDT_EN build).
// The reference model tracks the cycle at which the current hold began and
// the cycle at which release began, and derives outputs arithmetically.
// -----------------------------------------------------------------------------
module tb_svc_rst_seq;

   localparam int N    = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 4;
   localparam int TMO  = 1024;
   localparam int WDT  = 64;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         locked = 1'b1;
   logic         sw_rst_req = 1'b0;
   logic [N-1:0] stage_rst;
   logic         ready;
   logic         lock_fail;
   logic [7:0]   reset_count;
`ifdef SVC_RST_SEQ_WDT_EN
   logic         wdt_kick = 1'b1;
   logic         wdt_fired;
`endif

   always #5 clk = ~clk;

   svc_rst_seq #(
      .NUM_STAGES   (N),
      .HOLD_CYCLES  (HOLD),
      .STAGE_GAP    (GAP),
      .LOCK_TIMEOUT (TMO),
      .WDT_CYCLES   (WDT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .locked      (locked),
      .sw_rst_req  (sw_rst_req),
`ifdef SVC_RST_SEQ_WDT_EN
      .wdt_kick    (wdt_kick),
      .wdt_fired   (wdt_fired),
`endif
      .stage_rst   (stage_rst),
      .ready       (ready),
      .lock_fail   (lock_fail),
      .reset_count (reset_count)
   );

   initial begin
      #2000000;
      $display("FAIL time_limit: simulation did not finish in time");
      $fatal(1, "time limit");
   end

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   int   m_start;   // cycle the current hold began
   int   m_rel;     // cycle release began, -1 while not released
   int   m_low;     // consecutive unlocked cycles while waiting for lock
   int   m_rc;
   logic m_lf;

   task automatic model_reset();
      m_start = 0;
      m_rel   = -1;
      m_low   = 0;
      m_rc    = 0;
      m_lf    = 1'b0;
   endtask

   // Applies the inputs present during cycle 'cyc'.
   task automatic model_step(input logic sw, input logic lk);
      if (sw && m_rc < 255) m_rc++;
      if (m_rel >= 0) begin
         if (!lk || sw) begin
            m_start = cyc + 1;
            m_rel   = -1;
         end
      end else if (cyc - m_start < HOLD) begin
         m_low = 0;
         if (sw) m_start = cyc + 1;
      end else begin
         if (!lk) m_low++;
         if (!lk && m_low == TMO) begin
            m_lf    = 1'b1;
            m_start = cyc + 1;
            m_low   = 0;
         end else if (sw) begin
            m_start = cyc + 1;
            m_low   = 0;
         end else if (lk) begin
            m_rel = cyc + 1;
            m_low = 0;
         end
      end
   endtask

   // {stage_rst, ready, lock_fail, reset_count}
   function automatic logic [12:0] model_out();
      logic [N-1:0] s;
      logic         r;
      int           d;
      s = '1;
      r = 1'b0;
      if (m_rel >= 0) begin
         d = cyc - m_rel;
         for (int i = 0; i < N; i++) s[i] = (d < i * GAP);
         r = (d >= (N - 1) * GAP + 1);
      end
      return {s, r, m_lf, 8'(m_rc)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      if (!rst) model_step(sw_rst_req, locked);
      @(posedge clk);
      #1;
      if (!rst) cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sw_rst_req = 1'b0;
      locked = 1'b1;
      repeat (3) tick();
      check("rst_stage", stage_rst, 3'b111);
      check("rst_ready", ready, 1'b0);
      check("rst_lock_fail", lock_fail, 1'b0);
      check("rst_count", reset_count, 8'd0);
      rst = 1'b0;
      cyc = 0;
      model_reset();
   endtask

   task automatic sw_pulse();
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
   endtask

   // ---------------- release timing table ----------------
   typedef struct {
      int         off;
      logic [2:0] stg;
      logic       rdy;
   } vec_t;

   vec_t tbl [9];

   task automatic run_table(input string tag, input int base);
      for (int i = 0; i < 9; i++) begin
         run_to(base + tbl[i].off);
         check({tag, "_stage"}, stage_rst, tbl[i].stg);
         check({tag, "_ready"}, ready, tbl[i].rdy);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [12:0] exp_q [$];

   // ---------------- test ----------------
   initial begin
      int          low_left;
      int          base;
      logic [12:0] got;
      logic [12:0] exp;

      tbl[0] = '{0,  3'b111, 1'b0};
      tbl[1] = '{16, 3'b111, 1'b0};
      tbl[2] = '{17, 3'b110, 1'b0};
      tbl[3] = '{20, 3'b110, 1'b0};
      tbl[4] = '{21, 3'b100, 1'b0};
      tbl[5] = '{24, 3'b100, 1'b0};
      tbl[6] = '{25, 3'b000, 1'b0};
      tbl[7] = '{26, 3'b000, 1'b1};
      tbl[8] = '{40, 3'b000, 1'b1};

      model_reset();
      do_reset();

      // Power-on release sequence
      run_table("por", 0);

      // Software reset in RUN: immediate reassert, then identical timing
      sw_pulse();
      base = cyc;
      check("sw_stage", stage_rst, 3'b111);
      check("sw_ready", ready, 1'b0);
      check("sw_count", reset_count, 8'd1);
      run_table("swseq", base);

      // Lock dropped between stage 0 and stage 1 release
      sw_pulse();
      base = cyc;
      run_to(base + 18);
      check("mid_stage_pre", stage_rst, 3'b110);
      locked = 1'b0;
      tick();
      locked = 1'b1;
      base = cyc;
      check("mid_stage", stage_rst, 3'b111);
      check("mid_ready", ready, 1'b0);
      check("mid_count", reset_count, 8'd2);
      run_to(base + 16);
      check("mid_rel_early", stage_rst, 3'b111);
      run_to(base + 17);
      check("mid_rel", stage_rst, 3'b110);

      // Lock timeout: request a restart and keep locked low
      sw_rst_req = 1'b1;
      locked = 1'b0;
      tick();
      sw_rst_req = 1'b0;
      base = cyc;
      check("to_count", reset_count, 8'd3);
      run_to(base + HOLD + TMO - 1);
      check("to_lf_before", lock_fail, 1'b0);
      tick();
      check("to_lf", lock_fail, 1'b1);
      check("to_stage", stage_rst, 3'b111);
      locked = 1'b1;
      base = cyc;
      run_to(base + 25);
      check("to_ready_early", ready, 1'b0);
      tick();
      check("to_ready", ready, 1'b1);
      check("to_lf_sticky", lock_fail, 1'b1);
      check("to_count_kept", reset_count, 8'd3);

      // Randomized traffic against the model
      low_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (low_left > 0) begin
            locked = 1'b0;
            low_left--;
         end else begin
            locked = 1'b1;
            if ($urandom_range(0, 29) == 0) low_left = $urandom_range(1, 5);
         end
         sw_rst_req = ($urandom_range(0, 39) == 0);
         tick();
         exp_q.push_back(model_out());
         got = {stage_rst, ready, lock_fail, reset_count};
         exp = exp_q.pop_front();
         check("rand_outs", got, exp);
      end
      sw_rst_req = 1'b0;
      locked = 1'b1;

      // reset_count saturation
      for (int i = 0; i < 300; i++) begin
         sw_pulse();
         repeat (19) tick();
      end
      check("sat_count", reset_count, 8'd255);
      got = {stage_rst, ready, lock_fail, reset_count};
      check("sat_outs", got, model_out());

      // rst clears the sticky flag and the count
      do_reset();

`ifdef SVC_RST_SEQ_WDT_EN
      // Watchdog fires after WDT unkicked RUN cycles
      wdt_kick = 1'b1;
      run_to(26);
      check("wdt_run", ready, 1'b1);
      wdt_kick = 1'b0;
      run_to(26 + WDT - 1);
      check("wdt_not_yet", wdt_fired, 1'b0);
      tick();
      check("wdt_fired", wdt_fired, 1'b1);
      check("wdt_stage", stage_rst, 3'b111);
      check("wdt_count", reset_count, 8'd1);

      // Periodic kicks keep it quiet
      do_reset();
      for (int i = 0; i < 300; i++) begin
         wdt_kick = (cyc % 32 == 0);
         tick();
      end
      check("wdt_kicked", wdt_fired, 1'b0);
      check("wdt_kicked_ready", ready, 1'b1);
      wdt_kick = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
